// File: rtl/adc_tick_pkg.sv
// adc_tick_pkg: shared defaults for the ADC tick generator
package adc_tick_pkg;
  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_CNT_W   = 15;
  localparam int DEFAULT_DIV = 29405;
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adc_tick_ch.sv
// adc_tick_ch: one tick channel (count, active/pending divisor, tick decode, sq)
// The sq flop exists only when ADC_TICK_SQUARE_EN is defined.
module adc_tick_ch
  import adc_tick_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = adc_tick_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, pnd_q, pnd_d;
  logic pflag_q, pflag_d, wrap, apply;
  assign wrap  = en && cnt_q == act_q;
  assign tick  = wrap && !sync;
  // A staged divisor only takes over at a period boundary, so no period is ever cut short.
  assign apply = pflag_q && (sync || !en || wrap);
  assign pend  = pflag_q;
  always_comb begin
    cnt_d   = (sync || wrap || !en) ? '0 : cnt_q + 1'b1;
    act_d   = apply ? pnd_q : act_q;
    pnd_d   = wr ? wr_div : pnd_q;
    pflag_d = wr || (pflag_q && !apply);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      act_q   <= RST_DIV;
      pnd_q   <= RST_DIV;
      pflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pnd_q   <= pnd_d;
      pflag_q <= pflag_d;
    end
  end
`ifdef ADC_TICK_SQUARE_EN
  logic sq_q, sq_d;
  assign sq_d = (sync || !en) ? 1'b0 : sq_q ^ tick;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sq_q <= 1'b0;
    else     sq_q <= sq_d;
  end
  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif
endmodule

// File: rtl/adc_tick_gen.sv
// adc_tick_gen: NUM_CH programmable tick channels with shared sync and divisor write port
// Square-wave outputs are built only with ADC_TICK_SQUARE_EN defined.
module adc_tick_gen
  import adc_tick_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = adc_tick_pkg::DEFAULT_DIV,
  localparam int CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);
  localparam int PW = 2 ** CH_W;
  logic [NUM_CH-1:0] pend;
  logic [PW-1:0] pend_x;
  // Unused index slots read as not-pending, so out-of-range writes see ready and are dropped.
  assign pend_x    = PW'(pend);
  assign cfg_ready = !pend_x[cfg_ch];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    adc_tick_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (ch_en[i]),
      .sync  (sync),
      .wr    (cfg_valid && cfg_ready && cfg_ch == CH_W'(i)),
      .wr_div(cfg_div),
      .tick  (tick[i]),
      .sq    (sq[i]),
      .pend  (pend[i])
    );
  end
endmodule

// File: tb/tb_adc_tick_gen.sv
// tb_adc_tick_gen: scoreboard bench for adc_tick_gen; sq expectations follow ADC_TICK_SQUARE_EN
module tb_adc_tick_gen;
  localparam int N  = 4;
  localparam int W  = 15;
  localparam int DD = 29405;
`ifdef ADC_TICK_SQUARE_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, sync = 1'b0, cfg_valid = 1'b0, cfg_ready;
  logic [N-1:0] ch_en = '0, tick, sq, esq = '0;
  logic [1:0] cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  int cyc = 0, nvec = 0, nfail = 0;
  typedef struct {int c; int ch;} ev_t;
  ev_t sb[$];

  adc_tick_gen dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .sync     (sync),
    .cfg_valid(cfg_valid),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .tick     (tick),
    .sq       (sq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cycle(input logic r, input logic [N-1:0] en, input logic sy, input logic v,
                       input int ch, input int div);
    @(posedge clk); #1;
    rst = r; ch_en = en; sync = sy; cfg_valid = v; cfg_ch = 2'(ch); cfg_div = W'(div);
    @(negedge clk);
  endtask

  function automatic void push_per(input int ch, input int start, input int d, input int last);
    for (int c = start + d; c <= last; c += d + 1) begin
      int k = 0;
      while (k < sb.size() && sb[k].c <= c) k++;
      sb.insert(k, '{c, ch});
    end
  endfunction

  function automatic logic [N-1:0] pop_exp();
    logic [N-1:0] e = '0;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e[sb[0].ch] = 1'b1;
      void'(sb.pop_front());
    end
    return e;
  endfunction

  function automatic logic [N-1:0] sq_next(input logic [N-1:0] e, input logic [N-1:0] en, input logic sy);
    return (SQ && !sy) ? (esq ^ e) & en : '0;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, '1, 0, 1, 3, 7);
      nvec++; if (tick !== '0) begin nfail++; $display("FAIL reset tick got=%b exp=0000", tick); end
      nvec++; if (sq !== '0) begin nfail++; $display("FAIL reset sq got=%b exp=0000", sq); end
      nvec++; if (cfg_ready !== 1'b1) begin nfail++; $display("FAIL reset ready got=%b exp=1", cfg_ready); end
    end
  endtask

  task automatic test_reset_pending();
    logic [N-1:0] e;
    int t1;
    bit er;
    int sch[3] = '{2, 3, 3};
    int sdv[3] = '{0, 1, 0};
    sb.delete(); esq = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, '1, 1, i < 2, sch[i], sdv[i]);
      er = (i != 2);
      nvec++; if (tick !== '0) begin nfail++; $display("FAIL rstpend setup tick cyc=%0d got=%b exp=0000", cyc, tick); end
      nvec++; if (cfg_ready !== er) begin nfail++; $display("FAIL rstpend setup ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, er); end
    end
    t1 = cyc + 1;
    push_per(2, t1, 0, t1 + 2);
    push_per(3, t1, 1, t1 + 2);
    for (int i = 0; i < 3; i++) begin
      cycle(0, '1, 0, i == 1, 3, 5);
      e = pop_exp();
      er = (i != 2);
      nvec++; if (tick !== e) begin nfail++; $display("FAIL rstpend tick cyc=%0d got=%b exp=%b", cyc, tick, e); end
      nvec++; if (sq !== esq) begin nfail++; $display("FAIL rstpend sq cyc=%0d got=%b exp=%b", cyc, sq, esq); end
      nvec++; if (cfg_ready !== er) begin nfail++; $display("FAIL rstpend ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, er); end
      esq = sq_next(e, ch_en, sync);
    end
    cycle(1, '1, 0, 0, 3, 0);
    esq = '0;
    nvec++; if (tick !== '0) begin nfail++; $display("FAIL rstpend rst tick got=%b exp=0000", tick); end
    nvec++; if (sq !== '0) begin nfail++; $display("FAIL rstpend rst sq got=%b exp=0000", sq); end
    nvec++; if (cfg_ready !== 1'b1) begin nfail++; $display("FAIL rstpend rst ready got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_default();
    logic [N-1:0] e;
    int t0, tend;
    bit er;
    sb.delete();
    t0 = cyc + 1;
    tend = t0 + 2 * DD + 5;
    push_per(0, t0, DD, tend);
    push_per(2, t0, DD, tend);
    push_per(3, t0, DD, tend);
    push_per(1, t0, DD, t0 + DD);
    push_per(1, t0 + DD + 1, 3, tend);
    for (int i = 0; i <= tend - t0; i++) begin
      cycle(0, '1, 0, i == 10, 1, 3);
      e = pop_exp();
      er = (i <= 10 || i > DD);
      nvec++; if (tick !== e) begin nfail++; $display("FAIL default tick cyc=%0d got=%b exp=%b", cyc, tick, e); end
      nvec++; if (sq !== esq) begin nfail++; $display("FAIL default sq cyc=%0d got=%b exp=%b", cyc, sq, esq); end
      nvec++; if (cfg_ready !== er) begin nfail++; $display("FAIL default ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, er); end
      esq = sq_next(e, ch_en, sync);
    end
  endtask

  task automatic test_sync();
    logic [N-1:0] e;
    int t1, t2, tend;
    bit er;
    int sch[4] = '{0, 3, 2, 1};
    int sdv[4] = '{5, 7, 2, 0};
    int pre[4] = '{5, 3, 2, 7};
    int pst[4] = '{5, 1, 2, 7};
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      cycle(0, '1, 1, i < 3, sch[i], sdv[i]);
      nvec++; if (tick !== '0) begin nfail++; $display("FAIL sync setup tick cyc=%0d got=%b exp=0000", cyc, tick); end
      nvec++; if (cfg_ready !== 1'b1) begin nfail++; $display("FAIL sync setup ready cyc=%0d got=%b exp=1", cyc, cfg_ready); end
      esq = sq_next('0, ch_en, sync);
    end
    t1 = cyc + 1;
    t2 = t1 + 12;
    tend = t2 + 24;
    for (int c = 0; c < N; c++) begin
      push_per(c, t1, pre[c], t1 + 10);
      push_per(c, t2, pst[c], tend);
    end
    for (int i = 0; i <= tend - t1; i++) begin
      cycle(0, '1, i == 11, i == 8, 1, 1);
      e = pop_exp();
      er = !(i >= 9 && i <= 11);
      nvec++; if (tick !== e) begin nfail++; $display("FAIL sync tick cyc=%0d got=%b exp=%b", cyc, tick, e); end
      nvec++; if (sq !== esq) begin nfail++; $display("FAIL sync sq cyc=%0d got=%b exp=%b", cyc, sq, esq); end
      nvec++; if (cfg_ready !== er) begin nfail++; $display("FAIL sync ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, er); end
      esq = sq_next(e, ch_en, sync);
    end
  endtask

  task automatic test_zero_div();
    logic [N-1:0] e;
    int t1, tend;
    bit er;
    sb.delete();
    cycle(0, '1, 1, 0, 2, 0);
    nvec++; if (tick !== '0) begin nfail++; $display("FAIL zero sync tick got=%b exp=0000", tick); end
    esq = sq_next('0, ch_en, sync);
    t1 = cyc + 1;
    tend = t1 + 20;
    push_per(0, t1, 5, tend);
    push_per(1, t1, 1, tend);
    push_per(3, t1, 7, tend);
    push_per(2, t1, 2, t1 + 2);
    push_per(2, t1 + 3, 0, tend);
    for (int i = 0; i <= tend - t1; i++) begin
      cycle(0, '1, 0, i == 0, 2, 0);
      e = pop_exp();
      er = !(i == 1 || i == 2);
      nvec++; if (tick !== e) begin nfail++; $display("FAIL zero tick cyc=%0d got=%b exp=%b", cyc, tick, e); end
      nvec++; if (sq !== esq) begin nfail++; $display("FAIL zero sq cyc=%0d got=%b exp=%b", cyc, sq, esq); end
      nvec++; if (cfg_ready !== er) begin nfail++; $display("FAIL zero ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, er); end
      esq = sq_next(e, ch_en, sync);
    end
  endtask

  task automatic test_disable();
    logic [N-1:0] e;
    int t1, tend;
    bit er;
    sb.delete();
    cycle(0, '1, 1, 0, 0, 0);
    nvec++; if (tick !== '0) begin nfail++; $display("FAIL disable sync tick got=%b exp=0000", tick); end
    esq = sq_next('0, ch_en, sync);
    t1 = cyc + 1;
    tend = t1 + 20;
    push_per(1, t1, 1, tend);
    push_per(2, t1, 0, tend);
    push_per(3, t1, 7, tend);
    push_per(0, t1 + 5, 2, tend);
    for (int i = 0; i <= tend - t1; i++) begin
      cycle(0, (i >= 2 && i <= 4) ? 4'b1110 : 4'b1111, 0, i == 0, 0, 2);
      e = pop_exp();
      er = !(i == 1 || i == 2);
      nvec++; if (tick !== e) begin nfail++; $display("FAIL disable tick cyc=%0d got=%b exp=%b", cyc, tick, e); end
      nvec++; if (sq !== esq) begin nfail++; $display("FAIL disable sq cyc=%0d got=%b exp=%b", cyc, sq, esq); end
      nvec++; if (cfg_ready !== er) begin nfail++; $display("FAIL disable ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, er); end
      esq = sq_next(e, ch_en, sync);
    end
  endtask

  initial begin
    test_reset();
    test_reset_pending();
    test_default();
    test_sync();
    test_zero_div();
    test_disable();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
